// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer
//   Pops 32-bit mask patterns from the pattern FIFO and holds each one on
//   pattern_out for a programmed number of clk cycles, repeating until the
//   programmed pattern count is reached. Exposure length and pattern count
//   are captured at start so host wire-in changes mid-sequence are ignored.
//
// Ports
//   clk, rst_n        sequencer clock / async active-low reset
//   start, abort      one-cycle host trigger pulses (abort has priority)
//   exposure          cycles per pattern (0 is treated as 1)
//   num_patterns      patterns per sequence (0 completes immediately)
//   fifo_dout         FIFO read data, valid one cycle after fifo_rd_en
//   fifo_empty        FIFO empty flag
//   fifo_rd_en        FIFO read strobe (combinational, FETCH only)
//   pattern_out       registered mask pattern
//   pattern_load      one-cycle pulse when pattern_out takes a new value
//   exposure_active   high while the current pattern is exposed
//   busy              high whenever the sequencer is not IDLE
//   done              one-cycle pulse on normal completion
//   underrun          sticky: FIFO was empty when a pattern was needed
//   pattern_idx       patterns fully exposed in the current sequence
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | pop the next word once the FIFO is non-empty
// WAIT_DATA | FIFO read data in flight; captured at the end of this cycle
// EXPOSE    | pattern held for exp_reg cycles
// ---------------------------------------------------------------------------
module pattern_sequencer #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  exposure,
   input  logic [CNT_W-1:0]  num_patterns,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] pattern_out,
   output logic              pattern_load,
   output logic              exposure_active,
   output logic              busy,
   output logic              done,
   output logic              underrun,
   output logic [CNT_W-1:0]  pattern_idx
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FETCH     = 2'd1,
      WAIT_DATA = 2'd2,
      EXPOSE    = 2'd3
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    exp_reg_q;
   logic [CNT_W-1:0]    n_reg_q;
   logic [CNT_W-1:0]    exp_cnt_q;
   logic [CNT_W-1:0]    idx_q;
   logic [DATA_W-1:0]   pattern_q;
   logic                load_q;
   logic                expact_q;
   logic                busy_q;
   logic                done_q;
   logic                underrun_q;

   // The read strobe is not gated by abort: a word popped in the abort
   // cycle is consumed and simply never captured.
   assign fifo_rd_en = (state_q == FETCH) && !fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         exp_reg_q  <= '0;
         n_reg_q    <= '0;
         exp_cnt_q  <= '0;
         idx_q      <= '0;
         pattern_q  <= '0;
         load_q     <= 1'b0;
         expact_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         load_q <= 1'b0;
         done_q <= 1'b0;
         if (abort) begin
            // idx and underrun are left alone so the host can read them back
            state_q   <= IDLE;
            pattern_q <= '0;
            expact_q  <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     exp_reg_q  <= (exposure == '0) ? CNT_W'(1) : exposure;
                     n_reg_q    <= num_patterns;
                     idx_q      <= '0;
                     underrun_q <= 1'b0;
                     if (num_patterns == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                     end
                  end
               end
               FETCH: begin
                  if (!fifo_empty) begin
                     state_q <= WAIT_DATA;
                  end else begin
                     underrun_q <= 1'b1;
                  end
               end
               WAIT_DATA: begin
                  pattern_q <= fifo_dout;
                  exp_cnt_q <= exp_reg_q;
                  load_q    <= 1'b1;
                  expact_q  <= 1'b1;
                  state_q   <= EXPOSE;
               end
               EXPOSE: begin
                  exp_cnt_q <= exp_cnt_q - CNT_W'(1);
                  if (exp_cnt_q == CNT_W'(1)) begin
                     idx_q    <= idx_q + CNT_W'(1);
                     expact_q <= 1'b0;
                     // idx < n_reg always holds here, so idx+1 cannot wrap
                     if (idx_q + CNT_W'(1) == n_reg_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= FETCH;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign pattern_out     = pattern_q;
   assign pattern_load    = load_q;
   assign exposure_active = expact_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign underrun        = underrun_q;
   assign pattern_idx     = idx_q;

endmodule
